// File: rtl/mips_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Included first by every loader source file.
package mips_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 16;

  localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [ADDR_W-1:0] base,
    input logic [IDX_W-1:0]  idx
  );
    return base + {{(ADDR_W-IDX_W-2){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word assembler: shifts bytes in MSB first
// and flags the cycle in which the fourth byte arrives.
module word_assembler
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clr) begin
      cnt_d = 2'd0;
    end else if (en) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {sr_q[15:0], in_byte};
    end
  end

  assign word_valid = en && !clr && (cnt_q == 2'd3);
  assign word       = {sr_q, in_byte};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 2'd0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Framed byte-stream loader: writes words into instruction memory
// and releases the CPU once the frame checksum matches.
module inst_loader
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 1024,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              im_wen,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] n_hi_q, n_hi_d;
  logic [IDX_W-1:0]  n_q, n_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [BYTE_W-1:0] xor_q, xor_d;
  logic              in_ready_q, in_ready_d;
  logic              im_wen_q, im_wen_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [WORD_W-1:0] im_wdata_q, im_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic              term;
  logic              do_restart;
  logic              sync_hit;
  logic [IDX_W-1:0]  n_full;
  logic              n_over;
  logic              last_word;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  assign accept     = in_valid && in_ready_q;
  assign term       = (state_q == S_DONE) || (state_q == S_ERROR);
  assign do_restart = restart && term;
  assign sync_hit   = accept && (state_q == S_IDLE)
                   && (in_data == SYNC_BYTE);
  assign n_full     = {n_hi_q, in_data};
  assign n_over     = {16'd0, n_full} > 32'(MAX_WORDS);
  assign last_word  = (widx_q + 16'd1) == n_q;

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (do_restart),
    .en         (accept && (state_q == S_DATA)),
    .in_byte    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (sync_hit) state_d = S_CNT_HI;
      S_CNT_HI: if (accept) state_d = S_CNT_LO;
      S_CNT_LO: if (accept) begin
        if (n_over)            state_d = S_ERROR;
        else if (n_full == 0)  state_d = S_CSUM;
        else                   state_d = S_DATA;
      end
      S_DATA:   if (word_valid && last_word) state_d = S_CSUM;
      S_CSUM:   if (accept) begin
        state_d = (in_data == xor_q) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: if (restart) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    n_hi_d     = n_hi_q;
    n_d        = n_q;
    widx_d     = widx_q;
    xor_d      = xor_q;
    in_ready_d = !((state_d == S_DONE) || (state_d == S_ERROR));
    cpu_rst_d  = state_d != S_DONE;
    done_d     = state_d == S_DONE;
    error_d    = state_d == S_ERROR;
    im_wen_d   = word_valid;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    if (sync_hit || do_restart) begin
      widx_d = '0;
      xor_d  = '0;
    end
    // Sync byte is outside the checksum; count and data bytes are in.
    if (accept && (state_q inside {S_CNT_HI, S_CNT_LO, S_DATA}))
      xor_d = xor_q ^ in_data;
    if (accept && (state_q == S_CNT_HI)) n_hi_d = in_data;
    if (accept && (state_q == S_CNT_LO)) n_d = n_full;
    if (word_valid) begin
      widx_d     = widx_q + 16'd1;
      im_addr_d  = word_addr(BASE_ADDR, widx_q);
      im_wdata_d = word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_hi_q     <= '0;
      n_q        <= '0;
      widx_q     <= '0;
      xor_q      <= '0;
      in_ready_q <= 1'b1;
      im_wen_q   <= 1'b0;
      im_addr_q  <= BASE_ADDR;
      im_wdata_q <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      n_hi_q     <= n_hi_d;
      n_q        <= n_d;
      widx_q     <= widx_d;
      xor_q      <= xor_d;
      in_ready_q <= in_ready_d;
      im_wen_q   <= im_wen_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready = in_ready_q;
  assign im_wen   = im_wen_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
